lsu_mem_arbiter: RTL
====================

# lsu_mem_arbiter

Shares the single-ported data RAM between the `NUM_LANES` LSU lanes of a VLIW bundle. Each cycle it grants the RAM port to one requesting lane. It asserts a stall to the hazard unit until every memory op in the bundle has been served, in ascending lane order. It routes each read response back to its lane and holds it until that lane's writeback samples it. It sits between the LSU execute/writeback stages and the RAM.

## Interface
Parameters:
- `NUM_LANES`, 2: number of LSU lanes sharing the RAM (≥2)
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `lane_rd_en`  in  NUM_LANES  per-lane load request (from LSU execute `rd_en`)
- `lane_wr_en`  in  NUM_LANES  per-lane store request (from LSU execute `wr_en`)
- `lane_rd_addr`  in  NUM_LANES×ADDR_W  per-lane load address
- `lane_wr_addr`  in  NUM_LANES×ADDR_W  per-lane store address
- `lane_wr_data`  in  NUM_LANES×DATA_W  per-lane store data
- `lane_rd_data`  out  NUM_LANES×DATA_W  per-lane load data to LSU writeback `rd_data`
- `ext_stall`  in  1  stall from hazard detection (pipeline frozen for other reasons)
- `branch_squash`  in  1  squash of in-flight bundle
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wr_data`  out  DATA_W  RAM write data
- `ram_wr_en`  out  1  RAM write strobe
- `ram_rd_en`  out  1  RAM read strobe
- `ram_rd_data`  in  DATA_W  RAM read data, valid 1 cycle after `ram_rd_en`
- `mem_stall`  out  1  to hazard unit: bundle memory ops not all served

## Operation
- Request vector: `req[i] = (lane_rd_en[i] | lane_wr_en[i]) & ~served[i] & ~branch_squash`.
- If both enables are set on one lane, the store wins and the load is ignored.
- Grant: lowest-index set bit of `req` (fixed priority = bundle program order). One-hot `grant`, or zero when `req` is zero.
- RAM port is driven from the granted lane:
  - `ram_wr_en = grant lane wr_en`
  - `ram_rd_en = grant lane rd_en & ~wr_en`
  - `ram_addr` is the store or load address accordingly
  - `ram_wr_data` is that lane's store data
  - All RAM outputs are 0 when there is no grant.
- `mem_stall = |(req & ~grant)`, combinational, same cycle.
- `served` register (NUM_LANES bits):
  - If `mem_stall | ext_stall`: `served <= served | grant`.
  - Else: `served <= 0`.
  - `branch_squash` forces `served <= 0`.
- Response tracking, registered each cycle:
  - `rsp_valid <= ram_rd_en`
  - `rsp_lane <= index(grant)`
- Read return:
  - `lane_rd_data[i] = (rsp_valid & rsp_lane==i) ? ram_rd_data : hold[i]`
  - `hold[i] <= ram_rd_data` whenever `rsp_valid & rsp_lane==i`.
- A lane never served retains its stale `hold` value. LSU writeback ignores it because that lane is not a load.

## Timing
- Reset values:
  - `served`, `rsp_valid`, `rsp_lane`, `hold[*]` = 0.
  - All `ram_*` outputs and `mem_stall` are combinational; 0 with no requests.
- Single request: granted in the same cycle, no stall, read data on `lane_rd_data` next cycle.
- k simultaneous requests: k cycles in the arbiter, `mem_stall` high for the first k−1.
- In every case the pipeline advances at the end of the cycle in which the last request is granted.
- Earlier-served loads are captured into `hold` and remain stable until the bundle's writeback cycle.
- The last-served load bypasses `hold` and appears directly in the writeback cycle.
- `ext_stall` high with `mem_stall` low: the served lane is recorded, so a repeated request is not re-issued to RAM. This avoids a double store.
- `branch_squash`:
  - No grant that cycle; `served` cleared.
  - An outstanding `rsp_valid` still updates `hold` (harmless).
- Asynchronous `rst` mid-stall: all state clears immediately; `mem_stall` follows the raw requests.

## Structure
- Package `lsu_arb_pkg`: `NUM_LANES` default, `lane_idx_t` (`$clog2(NUM_LANES)` bits), one-hot-to-index function.
- Sub-module `lsu_arb_prio_pick`: combinational lowest-index-first picker, `req` → one-hot `grant` + index.
- Top holds the `served`, `rsp_*` and `hold` registers and the port muxes.

## Test plan
- Lane0 load @0x100, lane1 idle, RAM returns 0xAAAA → no stall; `ram_rd_en` T; `lane_rd_data[0]`=0xAAAA at T+1.
- Lane0 load @0x10, lane1 load @0x20 (RAM data 0x11, 0x22):
  - T: grant0, `mem_stall`=1.
  - T+1: grant1, `mem_stall`=0.
  - T+2: `lane_rd_data[0]`=0x11 from `hold`, `lane_rd_data[1]`=0x22.
- Lane0 store 0x55 @0x40, lane1 load @0x40 → store issued first; the load returns 0x55 (order preserved).
- Two stores with `ext_stall` held 3 cycles → exactly two `ram_wr_en` pulses, none repeated.
- `branch_squash` during cycle 2 of a 2-lane conflict → no grant; `served` cleared; `mem_stall`=0.
- `rst` asserted mid-stall → `served`=0 immediately; stores re-arbitrate from lane0 after release.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and helpers for the LSU memory arbiter.
// Lane index type and a one-hot to binary index conversion.
package lsu_arb_pkg;
  localparam int NUM_LANES = 2;
  localparam int MAX_LANES = 32;

  typedef logic [$clog2(NUM_LANES)-1:0] lane_idx_t;

  // Index of the set bit in a one-hot vector; zero input maps to index 0.
  function automatic int unsigned oh2idx(input logic [MAX_LANES-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_LANES; i++)
      if (oh[i]) r = unsigned'(i);
    return r;
  endfunction
endpackage

// File: rtl/lsu_arb_prio_pick.sv
// Fixed-priority picker: the lowest-index request wins (bundle program order).
module lsu_arb_prio_pick
  import lsu_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end

  assign o_idx = IW'(oh2idx(MAX_LANES'(o_grant)));
endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one single-ported data RAM between the LSU lanes of a bundle,
// serving lanes in ascending order and stalling until all are served.
module lsu_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int NUM_LANES = lsu_arb_pkg::NUM_LANES,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LANES-1:0]              lane_rd_en,
  input  logic [NUM_LANES-1:0]              lane_wr_en,
  input  logic [NUM_LANES-1:0][ADDR_W-1:0]  lane_rd_addr,
  input  logic [NUM_LANES-1:0][ADDR_W-1:0]  lane_wr_addr,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  lane_wr_data,
  output logic [NUM_LANES-1:0][DATA_W-1:0]  lane_rd_data,
  input  logic                              ext_stall,
  input  logic                              branch_squash,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [DATA_W-1:0]                 ram_wr_data,
  output logic                              ram_wr_en,
  output logic                              ram_rd_en,
  input  logic [DATA_W-1:0]                 ram_rd_data,
  output logic                              mem_stall
);
  localparam int IW = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]             w_req;
  logic [NUM_LANES-1:0]             w_grant;
  logic [IW-1:0]                    w_gidx;
  logic                             w_any;
  logic [NUM_LANES-1:0]             r_served;
  logic                             r_rsp_valid;
  logic [IW-1:0]                    r_rsp_lane;
  logic [NUM_LANES-1:0][DATA_W-1:0] r_hold;

  assign w_req = (lane_rd_en | lane_wr_en) & ~r_served & {NUM_LANES{~branch_squash}};

  lsu_arb_prio_pick #(.N(NUM_LANES)) u_pick (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_any     = |w_grant;
  assign mem_stall = |(w_req & ~w_grant);

  // A lane with both enables set is treated as a store.
  always_comb begin
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    if (w_any) begin
      ram_wr_data = lane_wr_data[w_gidx];
      if (lane_wr_en[w_gidx]) begin
        ram_wr_en = 1'b1;
        ram_addr  = lane_wr_addr[w_gidx];
      end else begin
        ram_rd_en = lane_rd_en[w_gidx];
        ram_addr  = lane_rd_addr[w_gidx];
      end
    end
  end

  // Served lanes persist across any stall so a frozen bundle never re-issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_served    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_lane  <= '0;
    end else begin
      if (branch_squash)              r_served <= '0;
      else if (mem_stall | ext_stall) r_served <= r_served | w_grant;
      else                            r_served <= '0;
      r_rsp_valid <= ram_rd_en;
      r_rsp_lane  <= w_gidx;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic w_hit;
    assign w_hit = r_rsp_valid && (r_rsp_lane == IW'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_hold[i] <= '0;
      else if (w_hit) r_hold[i] <= ram_rd_data;
    end

    assign lane_rd_data[i] = w_hit ? ram_rd_data : r_hold[i];
  end
endmodule
